riscv_alu_md: RTL
=================

Name: riscv_alu_md

Overview:
- Parametrised, registered successor to the single-cycle RISC-V integer ALU.
- Executes all RV32I/RV64I ALU operations in 1 cycle.
- Adds the M-extension multiply/divide operations on an iterative datapath that takes WIDTH cycles.
- Sits in the execute stage behind a valid/ready handshake, so the core stalls on in_ready and out_valid.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two ≥ 8 (32 for RV32, 64 for RV64).
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- alu_control  in  5  opcode (see Behaviour)
- a  in  WIDTH  operand A (rs1)
- b  in  WIDTH  operand B (rs2/imm)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- busy  out  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0. rst mid-operation aborts it and discards its result. No out_valid follows.
- Accept: the request is accepted on a rising edge where in_valid && in_ready. a, b and alu_control are captured at accept. Input changes after accept have no effect.
- Opcodes 0-9 (1-cycle): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - Shifts use b[SHW-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
  - Arithmetic wraps modulo 2^WIDTH.
- Opcodes 10-17 (iterative): MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17.
  - MUL returns the low WIDTH bits of the product; the MULH variants return the high WIDTH bits.
  - Signedness follows RISC-V: MULHSU is signed a × unsigned b.
- Opcodes 18-31 are illegal: 1-cycle, result=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE, accept of a 1-cycle op: the result is computed and registered; go to DONE. out_valid is first high the cycle after accept (latency 1).
  - IDLE, accept of an M op:
    - Operands are converted to magnitudes, sign flags are latched, counter=WIDTH; go to CALC.
    - Multiply: shift-add, one multiplier bit per cycle into a 2×WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - CALC: counter decrements each cycle. When it reaches 0, sign correction is applied and the result is registered; go to DONE. out_valid is first high WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1 and result is held stable. On out_ready=1, go to IDLE. in_ready rises the following cycle; there is no back-to-back accept in the same cycle as the result handoff.
- Fixed latency per class: no early termination for zero operands.
- Divide by zero:
  - DIV/DIVU quotient = all ones.
  - REM/REMU = a.
  - Latency unchanged.
- Signed overflow (a = most negative, b = -1): DIV returns a; REM returns 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored, and the requester must hold it.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 → out_valid at accept+1, result=0x80000000. Hold out_ready=0 for 3 cycles → result stable and in_ready=0.
- SRA a=0x80000000 b=0x00000024 (shamt 4) → 0xF8000000. SLTU a=1 b=0xFFFFFFFF → 1. SLT on the same operands → 0.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000001. MULHU with the same operands → 0xFFFFFFFE. MULH → 0x00000000. MULHSU → 0xFFFFFFFF. Each result has out_valid exactly 33 cycles after accept.
- DIV a=-7 b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU a=100 b=0 → 0xFFFFFFFF; REMU → 100. DIV a=0x80000000 b=-1 → 0x80000000; REM → 0.
- Assert rst 10 cycles into a DIV → next cycle out_valid=0, in_ready=1, result=0. A following ADD 2+3 returns 5 with latency 1.
- Randomised back-to-back ops with random out_ready stalls, compared to a reference model. Repeat with WIDTH=64: MULHU of all-ones gives 0xFFFFFFFFFFFFFFFE with latency 65.

Source files
------------

// File: rtl/riscv_alu_md.sv
// Registered RISC-V integer ALU with an iterative M-extension multiply/divide unit.
// Single-cycle ops finish in one clock; MUL*/DIV*/REM* iterate one bit per clock.
module riscv_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

    logic [WIDTH-1:0]   alu_s, mag_a_s, mag_b_s, fin_s;
    logic               a_neg_s, b_neg_s, is_md_s, is_div_s;
    logic [WIDTH:0]     msum_s, trial_s, diff_s;
    logic [2*WIDTH-1:0] step_s, prod_s;
    logic [WIDTH-1:0]   rem_new_s;
    logic               qbit_s;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

    // single-cycle ALU operations
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (alu_control)
            OP_ADD:  alu_s = a + b;
            OP_SUB:  alu_s = a - b;
            OP_AND:  alu_s = a & b;
            OP_OR:   alu_s = a | b;
            OP_XOR:  alu_s = a ^ b;
            OP_SLL:  alu_s = a << b[SHW-1:0];
            OP_SRL:  alu_s = a >> b[SHW-1:0];
            OP_SRA:  alu_s = $signed(a) >>> b[SHW-1:0];
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    // operand magnitudes and sign flags for the iterative unit
    always_comb begin
        is_md_s  = (alu_control >= OP_MUL) && (alu_control <= OP_REMU);
        is_div_s = is_md_s && (alu_control >= OP_DIV);
        a_neg_s  = a[WIDTH-1] && ((alu_control == OP_MULH) || (alu_control == OP_MULHSU) ||
                                  (alu_control == OP_DIV)  || (alu_control == OP_REM));
        b_neg_s  = b[WIDTH-1] && ((alu_control == OP_MULH) || (alu_control == OP_DIV) ||
                                  (alu_control == OP_REM));
        mag_a_s  = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
        mag_b_s  = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
    end

    // one iteration step: shift-add multiply or restoring divide ({rem, quot} in acc)
    always_comb begin
        if (acc_q[0]) begin
            msum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        end else begin
            msum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff_s  = trial_s - {1'b0, opnd_q};
        if (!diff_s[WIDTH]) begin
            rem_new_s = diff_s[WIDTH-1:0];
            qbit_s    = 1'b1;
        end else begin
            rem_new_s = trial_s[WIDTH-1:0];
            qbit_s    = 1'b0;
        end
        if (op_q >= OP_DIV) begin
            step_s = {rem_new_s, acc_q[WIDTH-2:0], qbit_s};
        end else begin
            step_s = {msum_s, acc_q[WIDTH-1:1]};
        end
    end

    // sign correction and result selection after the last step
    always_comb begin
        prod_s = negq_q ? ({(2*WIDTH){1'b0}} - step_s) : step_s;
        case (op_q)
            OP_MUL:                         fin_s = prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fin_s = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                if (dz_q) begin
                    fin_s = {WIDTH{1'b1}};
                end else begin
                    fin_s = negq_q ? ({WIDTH{1'b0}} - step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];
                end
            end
            OP_REM, OP_REMU: fin_s = negr_q ? ({WIDTH{1'b0}} - step_s[2*WIDTH-1:WIDTH])
                                            : step_s[2*WIDTH-1:WIDTH];
            default:                        fin_s = {WIDTH{1'b0}};
        endcase
    end

    // control FSM and datapath next state
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = alu_control;
                    if (is_md_s) begin
                        opnd_d  = is_div_s ? mag_b_s : mag_a_s;
                        acc_d   = {{WIDTH{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                        cnt_d   = CNT_INIT;
                        negq_d  = a_neg_s ^ b_neg_s;
                        negr_d  = a_neg_s;
                        dz_d    = (b == {WIDTH{1'b0}});
                        state_d = S_CALC;
                    end else begin
                        result_d = alu_s;
                        state_d  = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = step_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = fin_s;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= {WIDTH{1'b0}};
            op_q     <= 5'd0;
            opnd_q   <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
        end
    end
endmodule
